// File: rtl/pwm_dac_pkg.sv
// Shared definitions for the 4-bit PWM DAC and its upstream sample feeder.
package pwm_dac_pkg;

  localparam int DAC_WIDTH = 4;
  localparam int FRAME_LEN = 16;

  typedef logic [DAC_WIDTH-1:0] dac_code_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered occupancy count. The head entry is
// always visible on data_o; pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int Width = 4,
  parameter int Depth = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [Width-1:0]               data_i,
  output logic [Width-1:0]               data_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(Depth+1)-1:0]     level_o
);

  localparam int PtrWidth   = $clog2(Depth);
  localparam int LevelWidth = $clog2(Depth+1);
  localparam logic [LevelWidth-1:0] FullCount = LevelWidth'(Depth);

  logic [Width-1:0]      r_mem [Depth];
  logic [PtrWidth-1:0]   r_wrPtr;
  logic [PtrWidth-1:0]   r_rdPtr;
  logic [LevelWidth-1:0] r_count;
  logic                  w_doPush;
  logic                  w_doPop;

  assign full_o   = (r_count == FullCount);
  assign empty_o  = (r_count == '0);
  assign level_o  = r_count;
  assign data_o   = r_mem[r_rdPtr];
  assign w_doPush = push_i && !full_o;
  assign w_doPop  = pop_i && !empty_o;

  // Storage needs no reset: entries are only read once the count says they are valid.
  always_ff @(posedge clk_i) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= data_i;
    end
  end

  // Pointers wrap naturally because Depth is a power of two; the count moves only on unbalanced push/pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PtrWidth'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PtrWidth'(1);
      end
      if (w_doPush && !w_doPop) begin
        r_count <= r_count + LevelWidth'(1);
      end else if (w_doPop && !w_doPush) begin
        r_count <= r_count - LevelWidth'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_sample_feeder.sv
// Feeds duty codes to the PWM DAC. Codes are buffered in a FIFO and the DAC
// set value only changes on the edge that ends a PWM frame, so the DAC never
// sees a duty change mid-period. Empty-FIFO loads raise a sticky underrun.
module pwm_sample_feeder
  import pwm_dac_pkg::*;
#(
  parameter int DataWidth = DAC_WIDTH,
  parameter int FrameLen  = FRAME_LEN,
  parameter int FifoDepth = 4,
  parameter int HoldWidth = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               en_i,
  input  logic [HoldWidth-1:0]               hold_i,
  input  logic [DataWidth-1:0]               data_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  output logic [DataWidth-1:0]               set_o,
  output logic                               frame_o,
  output logic                               underrun_o,
  input  logic                               clear_i,
  output logic [$clog2(FifoDepth+1)-1:0]     level_o
);

  localparam int CntWidth   = $clog2(FrameLen);
  localparam int LevelWidth = $clog2(FifoDepth+1);
  localparam logic [CntWidth-1:0]  LastCnt = CntWidth'(FrameLen-1);
  localparam logic [HoldWidth:0]   HoldOne = (HoldWidth+1)'(1);

  logic [CntWidth-1:0]   r_frameCnt;
  logic [HoldWidth-1:0]  r_holdCnt;
  logic [HoldWidth-1:0]  r_holdQ;
  logic [DataWidth-1:0]  r_set;
  logic                  r_underrun;

  logic                  w_boundary;
  logic                  w_loadDue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_underrunEvt;
  logic                  w_full;
  logic                  w_empty;
  logic [DataWidth-1:0]  w_head;
  logic [LevelWidth-1:0] w_level;
  logic [HoldWidth:0]    w_holdTarget;
  logic [HoldWidth:0]    w_holdNext;

  // The hold comparison is done one bit wider so hold_cnt+1 can never wrap.
  assign w_boundary    = (r_frameCnt == LastCnt);
  assign w_holdTarget  = (r_holdQ == '0) ? HoldOne : {1'b0, r_holdQ};
  assign w_holdNext    = {1'b0, r_holdCnt} + HoldOne;
  assign w_loadDue     = (w_holdNext >= w_holdTarget);
  assign w_pop         = w_boundary && en_i && w_loadDue && !w_empty;
  assign w_underrunEvt = w_boundary && en_i && w_loadDue && w_empty;
  assign w_push        = valid_i && !w_full;

  assign ready_o    = !w_full;
  assign set_o      = r_set;
  assign frame_o    = (r_frameCnt == '0);
  assign underrun_o = r_underrun;
  assign level_o    = w_level;

  sync_fifo #(
    .Width (DataWidth),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (data_i),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (w_level)
  );

  // Free-running frame counter that ignores enable so it stays phase-locked to the DAC counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_frameCnt <= '0;
    end else begin
      r_frameCnt <= r_frameCnt + CntWidth'(1);
    end
  end

  // Output code and hold bookkeeping only move on the edge that ends a frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_set     <= '0;
      r_holdCnt <= '0;
      r_holdQ   <= HoldWidth'(1);
    end else if (w_boundary) begin
      if (!en_i) begin
        r_set     <= '0;
        r_holdCnt <= '0;
        r_holdQ   <= HoldWidth'(1);
      end else if (w_loadDue) begin
        if (!w_empty) begin
          r_set     <= w_head;
          r_holdQ   <= hold_i;
          r_holdCnt <= '0;
        end
      end else begin
        r_holdCnt <= r_holdCnt + HoldWidth'(1);
      end
    end
  end

  // Sticky underrun flag; a fresh underrun beats a simultaneous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_underrun <= 1'b0;
    end else if (w_underrunEvt) begin
      r_underrun <= 1'b1;
    end else if (clear_i) begin
      r_underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Testbench for pwm_sample_feeder: frame-level behavioural model with a
// scoreboard of expected codes checked whenever the DUT starts a new frame.
module tb_pwm_sample_feeder;

  localparam int DW = 4;
  localparam int FL = 16;
  localparam int FD = 4;
  localparam int HW = 8;
  localparam int LW = $clog2(FD+1);

  typedef struct {
    int code;
    int und;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [HW-1:0] hold;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic [DW-1:0] setCode;
  logic          frame;
  logic          underrun;
  logic          clear;
  logic [LW-1:0] level;

  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];

  int   mQ[$];
  int   mSet;
  int   mUnd;
  int   mFramesLeft;
  int   mFrameCnt;

  always #5 clk = ~clk;

  pwm_sample_feeder #(
    .DataWidth (DW),
    .FrameLen  (FL),
    .FifoDepth (FD),
    .HoldWidth (HW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .hold_i     (hold),
    .data_i     (data),
    .valid_i    (valid),
    .ready_o    (ready),
    .set_o      (setCode),
    .frame_o    (frame),
    .underrun_o (underrun),
    .clear_i    (clear),
    .level_o    (level)
  );

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    expQ.delete();
    mSet        = 0;
    mUnd        = 0;
    mFramesLeft = 1;
    mFrameCnt   = 0;
  endtask

  // One clock of stimulus: check the DUT against the model, drive inputs, advance the model across the next edge.
  task automatic applyStimulus(input bit v, input int d, input int h, input bit e, input bit c);
    bit   accept;
    bit   newUnd;
    exp_t ex;
    checkOutput("set_o", int'(setCode), mSet);
    checkOutput("underrun_o", int'(underrun), mUnd);
    checkOutput("level_o", int'(level), mQ.size());
    checkOutput("ready_o", int'(ready), int'(mQ.size() < FD));
    checkOutput("frame_o", int'(frame), int'(mFrameCnt == 0));
    valid  = v;
    data   = d[DW-1:0];
    hold   = h[HW-1:0];
    en     = e;
    clear  = c;
    accept = v && (mQ.size() < FD);
    newUnd = 1'b0;
    if (mFrameCnt == FL-1) begin
      if (!e) begin
        mSet        = 0;
        mFramesLeft = 1;
      end else if (mFramesLeft <= 1) begin
        if (mQ.size() > 0) begin
          mSet        = mQ.pop_front();
          mFramesLeft = (h == 0) ? 1 : h;
        end else begin
          newUnd = 1'b1;
        end
      end else begin
        mFramesLeft--;
      end
    end
    if (newUnd) mUnd = 1;
    else if (c) mUnd = 0;
    if (mFrameCnt == FL-1) begin
      ex.code = mSet;
      ex.und  = mUnd;
      expQ.push_back(ex);
    end
    if (accept) mQ.push_back(d);
    mFrameCnt = (mFrameCnt + 1) % FL;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input int h, input bit e);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, h, e, 1'b0);
  endtask

  task automatic randomRun(input int n, input int pValid, input int holdMax, input int pOff, input int pClear);
    for (int i = 0; i < n; i++) begin
      applyStimulus(($urandom % 100) < pValid, int'($urandom_range(15, 0)),
                    int'($urandom_range(holdMax, 0)), ($urandom % 100) >= pOff,
                    ($urandom % 100) < pClear);
    end
  endtask

  task automatic resetDut();
    rst   = 1'b1;
    valid = 1'b0;
    en    = 1'b0;
    clear = 1'b0;
    hold  = '0;
    data  = '0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    modelReset();
  endtask

  // Frame monitor: every frame start after a boundary must show the scoreboard's next code.
  initial begin : monitor
    exp_t got;
    forever begin
      @(negedge clk);
      if (!rst && frame) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL frame_start actual=frame_o_high required=no_frame_pending at %0t", $time);
        end else begin
          got = expQ.pop_front();
          checkOutput("frame_set", int'(setCode), got.code);
          checkOutput("frame_underrun", int'(underrun), got.und);
        end
      end
    end
  end

  initial begin : stimulus
    resetDut();

    // First load after reset
    applyStimulus(1'b1, 5, 1, 1'b1, 1'b0);
    idle(20, 1, 1'b1);
    checkOutput("first_load", int'(setCode), 5);

    // Three samples each held three frames
    applyStimulus(1'b1, 3, 3, 1'b1, 1'b0);
    applyStimulus(1'b1, 9, 3, 1'b1, 1'b0);
    applyStimulus(1'b1, 12, 3, 1'b1, 1'b0);
    idle(200, 3, 1'b1);

    // Underrun with a single sample, clear, then refill
    applyStimulus(1'b0, 0, 1, 1'b1, 1'b1);
    applyStimulus(1'b1, 7, 1, 1'b1, 1'b0);
    idle(40, 1, 1'b1);
    checkOutput("underrun_hold_code", int'(setCode), 7);
    checkOutput("underrun_flag", int'(underrun), 1);
    applyStimulus(1'b0, 0, 1, 1'b1, 1'b1);
    idle(3, 1, 1'b1);
    applyStimulus(1'b1, 2, 1, 1'b1, 1'b0);
    idle(20, 1, 1'b1);

    // Fill the FIFO while disabled, then play it out
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 10 + i, 1, 1'b0, 1'b0);
    idle(20, 1, 1'b0);
    checkOutput("full_level", int'(level), 4);
    checkOutput("full_ready", int'(ready), 0);
    checkOutput("full_set", int'(setCode), 0);
    idle(100, 1, 1'b1);

    // Disable during a long hold, then re-enable
    applyStimulus(1'b1, 1, 5, 1'b1, 1'b1);
    applyStimulus(1'b1, 4, 5, 1'b1, 1'b0);
    applyStimulus(1'b1, 6, 5, 1'b1, 1'b0);
    idle(40, 5, 1'b1);
    idle(20, 5, 1'b0);
    idle(60, 5, 1'b1);

    // Randomised traffic
    for (int p = 0; p < 6; p++) begin
      randomRun(400, int'($urandom_range(90, 10)), int'($urandom_range(4, 0)),
                int'($urandom_range(30, 0)), int'($urandom_range(10, 0)));
    end

    // Asynchronous reset with three entries buffered
    while (mQ.size() < 3) applyStimulus(1'b1, int'($urandom_range(15, 0)), 1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_set", int'(setCode), 0);
    checkOutput("rst_ready", int'(ready), 1);
    checkOutput("rst_frame", int'(frame), 1);
    checkOutput("rst_underrun", int'(underrun), 0);
    checkOutput("rst_level", int'(level), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    modelReset();
    randomRun(300, 60, 3, 5, 5);

    checkOutput("frames_pending", int'(expQ.size() <= 1), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_sample_feeder.md
# pwm_sample_feeder

Upstream feeder for the 4-bit PWM DAC stage. It buffers duty-cycle codes arriving over a valid/ready stream in a small FIFO. It presents one code on `set_o` per PWM frame, or per N frames, and changes `set_o` only at frame boundaries so the DAC never sees a mid-period duty change. Underruns are flagged and the last code is held.

## Interface
Parameters:
- `DataWidth`, 4, code width; must equal the DAC `set_i` width.
- `FrameLen`, 16, PWM period in clocks; fixed at 2**DataWidth to match the DAC free-running counter.
- `FifoDepth`, 4, sample buffer entries; power of two, ≥2.
- `HoldWidth`, 8, width of the frames-per-sample field.

Ports:
- Reset is asynchronous and active-high; the design has one clock, `clk_i`.
- `clk_i` in 1: clock, shared with the DAC.
- `rst_i` in 1: async active-high reset. The top level drives the DAC `rst_ni` as `~rst_i`, so both counters leave reset together.
- `en_i` in 1: playback enable.
- `hold_i` in HoldWidth: frames each sample is held; 0 is treated as 1; sampled at each load.
- `data_i` in DataWidth: sample code.
- `valid_i` in 1: sample valid.
- `ready_o` out 1: FIFO can accept.
- `set_o` out DataWidth: duty code to DAC `set_i`; registered.
- `frame_o` out 1: high in the first cycle of each frame.
- `underrun_o` out 1: sticky, set when a load finds the FIFO empty.
- `clear_i` in 1: clears `underrun_o`.
- `level_o` out $clog2(FifoDepth+1): FIFO occupancy.

## Operation
- **Frame counter:** `frame_cnt` counts 0..FrameLen-1, wraps, and is free-running. It ignores `en_i` so it stays aligned with the DAC counter.
- **Boundary:** the cycle where `frame_cnt == FrameLen-1` is the boundary cycle. All `set_o` updates occur on the clock edge that ends it.
- **Hold counter:** `hold_cnt` counts elapsed frames of the current sample. A load is due at a boundary when `hold_cnt + 1 >= max(hold_q, 1)`. `hold_q` is the `hold_i` value captured at the previous load.
- **Boundary with `en_i` high and a load due:**
  - FIFO non-empty: pop, `set_o <=` head, `hold_q <= hold_i`, `hold_cnt <= 0`.
  - FIFO empty: `set_o` unchanged, `underrun_o <= 1`, `hold_cnt` unchanged. The load is retried at the next boundary.
- **Boundary with no load due:** `hold_cnt` increments.
- **Boundary with `en_i` low:** `set_o <= 0`, `hold_cnt <= 0`, `hold_q <= 1`. The first enabled boundary afterwards loads immediately.
- **FIFO:**
  - A push occurs when `valid_i && ready_o`.
  - `ready_o = (level < FifoDepth)`, computed from registered count only.
  - Push and pop in the same cycle: count unchanged, both take effect.
  - When empty, a same-cycle push is not bypassed to the pop; that boundary is an underrun.
  - Pushes are accepted regardless of `en_i`.
- **Underrun flag:** `clear_i` and a new underrun in the same cycle leave `underrun_o` set (set wins).
- **Arithmetic:** pointers are log2(FifoDepth) bits and wrap naturally. `level` saturates by construction and never exceeds FifoDepth.

## Timing
- Reset values: `set_o`=0, `ready_o`=1, `frame_o`=1 (frame_cnt=0), `underrun_o`=0, `level_o`=0.
- Internal reset values: `hold_cnt`=0, `hold_q`=1. Reset mid-operation discards FIFO contents.
- `set_o` changes only on the edge after a cycle with `frame_cnt==FrameLen-1`. The DAC therefore sees the new code starting at its count 0.
- Push to `level_o` increment: 1 cycle. Push to earliest appearance on `set_o`: the next boundary edge, at most FrameLen cycles later.
- `ready_o` deasserts the cycle after the push that fills the FIFO, since it is registered-count based.
- `frame_o` depends only on `frame_cnt` and has period FrameLen.

## Structure
- Package `pwm_dac_pkg`:
  - constants `DAC_WIDTH`=4 and `FRAME_LEN`=16;
  - typedef `dac_code_t` (logic [DAC_WIDTH-1:0]);
  - the same package is shared with the DAC top.
- Sub-module `sync_fifo`, parameterized on width and depth:
  - inputs: push/pop;
  - outputs: `full`, `empty`, `level`;
  - the feeder instantiates it with `DataWidth`/`FifoDepth`.
- The frame counter, hold counter and output register stay in the feeder.

## Test plan
- **Reset and first load:**
  - stimulus: push 4'd5, `hold_i`=1, `en_i`=1 after reset release;
  - response: `set_o`=0 through frame_cnt 15, then 5 from the edge ending cycle 15; `underrun_o`=0.
- **Hold:**
  - stimulus: push 3, 9, 12 with `hold_i`=3;
  - response: each code holds exactly 48 cycles, with transitions only at boundaries.
- **Underrun:**
  - stimulus: push a single 7, then nothing;
  - response: `set_o` stays 7, `underrun_o` rises at the next boundary, and `clear_i` drops it.
  - stimulus: push 2;
  - response: `set_o`=2 at the following boundary.
- **Full FIFO:**
  - stimulus: push 5 samples back-to-back, `en_i`=0;
  - response: 4 accepted, `ready_o` low after the 4th, `level_o`=4, `set_o`=0.
  - stimulus: raise `en_i`;
  - response: samples are played in order.
- **Disable mid-playback:**
  - stimulus: drop `en_i` during a hold of 5;
  - response: `set_o`=0 at the next boundary, FIFO unchanged.
  - stimulus: re-enable;
  - response: the head loads at the first boundary.
- **Reset mid-operation:**
  - stimulus: assert `rst_i` asynchronously with `level_o`=3;
  - response: all outputs return to reset values immediately and `frame_cnt` restarts aligned to the DAC.
